// File: rtl/seg7_ani_scheduler.sv
// rtl/seg7_ani_scheduler.sv - button arbitration, animation index, frame period and frame tick
//
// Control sequencer for the 7-segment animation datapath.
//   clk          system clock
//   rst_n        synchronous active-low reset
//   btn[3:0]     raw active-high buttons: [0] ani+, [1] ani-, [2] slower, [3] faster
//   auto_en      1 = auto-demo advances the animation every AUTO_LOOPS full loops
//   frame_limit  last frame index of the current animation
//   ani_sel      current animation index, 0..NUM_ANI-1
//   frame        current frame index, 0..frame_limit
//   frame_tick   one-cycle pulse per frame advance
//   period       current frame period in clk cycles
//   loop_done    one-cycle pulse with frame_tick when frame wraps to 0
module seg7_ani_scheduler #(
  parameter int unsigned NUM_ANI    = 12,
  parameter int unsigned DEB_CYCLES = 512,
  parameter int unsigned PER_DEF    = 10_000_000,
  parameter int unsigned PER_MIN    = 1_000_000,
  parameter int unsigned PER_MAX    = 20_000_000,
  parameter int unsigned PER_STEP   = 1_000_000,
  parameter int unsigned AUTO_LOOPS = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  btn,
  input  logic        auto_en,
  input  logic [4:0]  frame_limit,
  output logic [3:0]  ani_sel,
  output logic [4:0]  frame,
  output logic        frame_tick,
  output logic [23:0] period,
  output logic        loop_done
);

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int LW = (AUTO_LOOPS > 0) ? $clog2(AUTO_LOOPS + 1) : 1;

  // The period register is 24 bits wide, so the upper clamp is limited to what it can hold.
  localparam logic [23:0] P_MAX  = (PER_MAX > 32'h00FF_FFFF) ? 24'hFF_FFFF : 24'(PER_MAX);
  localparam logic [23:0] P_MIN  = 24'(PER_MIN);
  localparam logic [23:0] P_STEP = 24'(PER_STEP);
  localparam logic [23:0] P_DEF  = 24'(PER_DEF);

  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [3:0]    ANI_LAST = 4'(NUM_ANI - 1);
  localparam logic [LW-1:0] LOOPS    = LW'(AUTO_LOOPS);

  typedef enum logic [2:0] {
    EV_NONE,
    EV_ANI_UP,
    EV_ANI_DN,
    EV_SLOWER,
    EV_FASTER
  } ev_t;

  logic [DW-1:0] deb_cnt [4];
  logic [3:0]    held;
  logic [3:0]    btn_evt;
  logic          auto_evt;
  logic [23:0]   tcnt;
  logic [LW-1:0] lcnt;
  ev_t           ev;
  logic [24:0]   per_up;
  logic [23:0]   per_dn;
  logic          tick_due;
  logic          wrap;

  always_comb begin
    btn_evt = '0;
    // The counter saturates at DEB_LAST; the held flag keeps a long press to a single event.
    for (int i = 0; i < 4; i++) begin
      btn_evt[i] = btn[i] && !held[i] && (deb_cnt[i] == DEB_LAST);
    end
    auto_evt = auto_en && (lcnt >= LOOPS);

    ev = EV_NONE;
    if (btn_evt[0])      ev = EV_ANI_UP;
    else if (btn_evt[1]) ev = EV_ANI_DN;
    else if (btn_evt[2]) ev = EV_SLOWER;
    else if (btn_evt[3]) ev = EV_FASTER;
    else if (auto_evt)   ev = EV_ANI_UP;

    per_up = {1'b0, period} + {1'b0, P_STEP};
    per_dn = ({1'b0, period} < ({1'b0, P_MIN} + {1'b0, P_STEP})) ? P_MIN : (period - P_STEP);

    // Compare against the period as it stands this cycle; a shortened period below tcnt
    // therefore ticks on the next edge instead of running to the counter wrap.
    tick_due = (tcnt >= (period - 24'd1));
    wrap     = tick_due && (frame >= frame_limit);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
      held       <= '0;
      ani_sel    <= '0;
      frame      <= '0;
      frame_tick <= 1'b0;
      loop_done  <= 1'b0;
      period     <= P_DEF;
      tcnt       <= '0;
      lcnt       <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!btn[i])                   deb_cnt[i] <= '0;
        else if (deb_cnt[i] != DEB_LAST) deb_cnt[i] <= deb_cnt[i] + DW'(1);
      end
      held <= (held | btn_evt) & btn;

      frame_tick <= 1'b0;
      loop_done  <= 1'b0;

      case (ev)
        EV_SLOWER: period <= (per_up > {1'b0, P_MAX}) ? P_MAX : per_up[23:0];
        EV_FASTER: period <= per_dn;
        default:   ;
      endcase

      if (ev == EV_ANI_UP || ev == EV_ANI_DN) begin
        if (ev == EV_ANI_UP) ani_sel <= (ani_sel >= ANI_LAST) ? 4'd0 : ani_sel + 4'd1;
        else                 ani_sel <= (ani_sel == 4'd0) ? ANI_LAST : ani_sel - 4'd1;
        // A new animation restarts from its first frame with a full period and no tick.
        frame <= '0;
        tcnt  <= '0;
        lcnt  <= '0;
      end else begin
        if (tick_due) begin
          tcnt       <= '0;
          frame_tick <= 1'b1;
          if (wrap) begin
            frame     <= '0;
            loop_done <= 1'b1;
          end else begin
            frame <= frame + 5'd1;
          end
        end else begin
          tcnt <= tcnt + 24'd1;
        end

        // An auto event that lost to a speed button is still consumed.
        if (!auto_en || auto_evt) lcnt <= '0;
        else if (wrap)            lcnt <= lcnt + LW'(1);
      end
    end
  end

endmodule
